// File: rtl/cyclic_seq_fsm_if.sv
// ---------------------------------------------------------------------------
// cyclic_seq_fsm_if
//   Control/status bundle for the cyclic state sequencer.
//   Parameters:
//     STATE_W  width of the state index (must match the sequencer's STATE_W)
//     OUT_W    width of the decoded pattern output
//   Signals:
//     En, Start, Stop, Mode      control from the user (master) to the sequencer
//     Load, LoadState            direct state load, present only when
//                                CYC_SEQ_LOAD_EN is defined
//     Y, State, Busy, Wrap       status from the sequencer (slave) to the user
//   Modports:
//     master  drives the controls, observes the status
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface cyclic_seq_fsm_if #(
  parameter int STATE_W = 2,
  parameter int OUT_W   = 1
);
  logic               En;
  logic               Start;
  logic               Stop;
  logic               Mode;
`ifdef CYC_SEQ_LOAD_EN
  logic               Load;
  logic [STATE_W-1:0] LoadState;
`endif
  logic [OUT_W-1:0]   Y;
  logic [STATE_W-1:0] State;
  logic               Busy;
  logic               Wrap;

`ifdef CYC_SEQ_LOAD_EN
  modport master (output En, Start, Stop, Mode, Load, LoadState,
                  input  Y, State, Busy, Wrap);
  modport slave  (input  En, Start, Stop, Mode, Load, LoadState,
                  output Y, State, Busy, Wrap);
`else
  modport master (output En, Start, Stop, Mode,
                  input  Y, State, Busy, Wrap);
  modport slave  (input  En, Start, Stop, Mode,
                  output Y, State, Busy, Wrap);
`endif
endinterface

// File: rtl/cyclic_seq_fsm.sv
// ---------------------------------------------------------------------------
// cyclic_seq_fsm
//   Parametrised cyclic state sequencer. Steps a modulo-NUM_STATES state
//   index while a run is active and decodes a per-state output pattern.
//   Supports run/stop control, a per-cycle advance enable, free-running or
//   one-shot runs, and a registered wrap pulse.
//
//   Parameters:
//     NUM_STATES  number of states in the cycle (>= 1)
//     OUT_W       width of the decoded output Y
//     PATTERN     NUM_STATES*OUT_W bits; Y for state s is PATTERN[s*OUT_W +: OUT_W]
//
//   Ports:
//     Clk   clock, rising edge
//     Rst   asynchronous, active-low reset
//     bus   cyclic_seq_fsm_if.slave:
//             En     advance qualifier (only while Busy)
//             Start  begin a run (ignored while Busy); latches Mode
//             Stop   synchronous abort, highest priority
//             Mode   0 = free-running, 1 = one-shot
//             Y      combinational decode of State
//             State  current state index 0..NUM_STATES-1
//             Busy   run in progress
//             Wrap   one-cycle pulse in the cycle State returns to 0
//
//   Optional feature (macro CYC_SEQ_LOAD_EN):
//     Adds Load/LoadState. Load forces State to LoadState on the next edge
//     (clamped to NUM_STATES-1), leaves Busy unchanged and clears Wrap.
//     Priority: Stop > Load > Start > advance.
// ---------------------------------------------------------------------------
module cyclic_seq_fsm #(
  parameter int                          NUM_STATES = 3,
  parameter int                          OUT_W      = 1,
  parameter logic [NUM_STATES*OUT_W-1:0] PATTERN    = 3'b100,
  localparam int                         STATE_W    = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic           Clk,
  input  logic           Rst,
  cyclic_seq_fsm_if.slave bus
);

  localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);

  // The latched run mode is folded into the run state: a run is either
  // free-running or one-shot, so no separate mode register is needed and
  // reset (IDLE) implies mode 0.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RUN_FREE    = 2'd1,
    RUN_ONESHOT = 2'd2
  } run_e;

  run_e               run, run_nxt;
  logic [STATE_W-1:0] state_r, state_nxt;
  logic               wrap_r, wrap_nxt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      run     <= IDLE;
      state_r <= '0;
      wrap_r  <= 1'b0;
    end else begin
      run     <= run_nxt;
      state_r <= state_nxt;
      wrap_r  <= wrap_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    run_nxt   = run;
    state_nxt = state_r;
    wrap_nxt  = 1'b0;

    if (bus.Stop) begin
      run_nxt   = IDLE;
      state_nxt = '0;
`ifdef CYC_SEQ_LOAD_EN
    end else if (bus.Load) begin
      // Out-of-range load values clamp to the last state, so State can never
      // leave the legal range.
      state_nxt = (bus.LoadState > LAST) ? LAST : bus.LoadState;
`endif
    end else if (run == IDLE) begin
      // Accepting Start only arms the run; the first advance is possible on
      // the following edge.
      if (bus.Start) begin
        run_nxt = bus.Mode ? RUN_ONESHOT : RUN_FREE;
      end
    end else if (bus.En) begin
      // Explicit wrap compare rather than natural overflow, so that
      // non-power-of-two cycle lengths work.
      if (state_r == LAST) begin
        state_nxt = '0;
        wrap_nxt  = 1'b1;
        if (run == RUN_ONESHOT) begin
          run_nxt = IDLE;
        end
      end else begin
        state_nxt = state_r + STATE_W'(1);
      end
    end
  end

  assign bus.State = state_r;
  assign bus.Busy  = (run != IDLE);
  assign bus.Wrap  = wrap_r;
  assign bus.Y     = PATTERN[int'(state_r) * OUT_W +: OUT_W];

endmodule
